// File: rtl/montgomery_pkg.sv
// Shared definitions for the Montgomery multiplier control path, datapath and PE array.
package montgomery_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRECOMP = 2'd1,
        RUN     = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Iteration counter must be able to hold the value WIDTH.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_bit.sv
// One-bit full adder with a registered carry, used to build M+B serially.
module serial_adder_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);

    logic carry_q;

    assign sum  = a ^ b ^ carry_q;
    assign cout = (a & b) | (carry_q & (a ^ b));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else if (clr) begin
            carry_q <= 1'b0;
        end else if (en) begin
            carry_q <= cout;
        end
    end

endmodule

// File: rtl/montgomery_select_sequencer.sv
// Sequencer for the bit-serial Montgomery PE array: precomputes M+B, then steps the
// (a_i, q_i) select pair for WIDTH iterations.
module montgomery_select_sequencer
    import montgomery_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] m_in,
    input  logic             s0,
    output logic             step_en,
    output logic             ai,
    output logic             qi,
    output logic [WIDTH:0]   mb,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] Last = CntW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] m_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic             b_lsb_q;
    logic [WIDTH:0]   mb_q;
    logic [CntW-1:0]  cnt_q;

    logic accept;
    logic last;
    logic precomp;
    logic add_sum;
    logic add_cout;

    assign accept  = (state_q == IDLE) && start;
    assign last    = (cnt_q == Last);
    assign precomp = (state_q == PRECOMP);

    serial_adder_bit u_adder (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (precomp),
        .a     (m_sh_q[0]),
        .b     (b_sh_q[0]),
        .sum   (add_sum),
        .cout  (add_cout)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = PRECOMP;
            PRECOMP: if (last) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            m_sh_q  <= '0;
            b_sh_q  <= '0;
            b_lsb_q <= 1'b0;
            mb_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a_in;
                        m_sh_q  <= m_in;
                        b_sh_q  <= b_in;
                        b_lsb_q <= b_in[0];
                        mb_q    <= '0;
                        cnt_q   <= '0;
                    end
                end
                PRECOMP: begin
                    m_sh_q <= m_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    // Sum bits enter at the top; the final edge lands bit k at mb[k].
                    if (last) begin
                        mb_q  <= {add_cout, add_sum, mb_q[WIDTH:2]};
                        cnt_q <= '0;
                    end else begin
                        mb_q  <= {add_sum, mb_q[WIDTH:1]};
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    cnt_q <= cnt_q + CntW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // qi stays combinational so the s0 -> qi -> mux -> S loop closes in one cycle.
    assign step_en = (state_q == RUN);
    assign ai      = step_en & a_q[0];
    assign qi      = step_en & (s0 ^ (a_q[0] & b_lsb_q));
    assign mb      = mb_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_montgomery_select_sequencer.sv
// Scoreboard bench: the driver queues expected per-iteration selects; a negedge monitor checks.
module tb_montgomery_select_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         s0 = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [W-1:0] m_in = '0;
    logic         step_en, ai, qi, busy, done;
    logic [W:0]   mb;

    always #5 clk = ~clk;

    montgomery_select_sequencer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .m_in    (m_in),
        .s0      (s0),
        .step_en (step_en),
        .ai      (ai),
        .qi      (qi),
        .mb      (mb),
        .busy    (busy),
        .done    (done)
    );

    typedef struct packed {
        logic       ai;
        logic       qi;
        logic [W:0] mb;
    } step_t;

    step_t        step_q[$];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    bit           mon_en = 1'b0;
    bit           have_op = 1'b0;
    int           op_e = 0;
    logic [W-1:0] op_s0 = '0;
    logic [W:0]   mb_prev = '0;
    logic [W:0]   mb_cur = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: op accepted so that op_e is its first busy cycle.
    always @(negedge clk) begin
        bit    in_op, in_pre, in_run, is_done;
        step_t e;
        if (mon_en) begin
            in_op   = have_op && cyc >= op_e && cyc <= op_e + 2 * W;
            in_pre  = have_op && cyc >= op_e && cyc < op_e + W;
            in_run  = have_op && cyc >= op_e + W && cyc < op_e + 2 * W;
            is_done = have_op && cyc == op_e + 2 * W;
            chk("busy", busy, in_op);
            chk("step_en", step_en, in_run);
            chk("done", done, is_done);
            if (step_en) begin
                chk("step_available", step_q.size() > 0, 1);
                if (step_q.size() > 0) begin
                    e = step_q.pop_front();
                    chk("ai", ai, e.ai);
                    chk("qi", qi, e.qi);
                    chk("mb_run", mb, e.mb);
                end
            end else begin
                chk("ai_idle", ai, 0);
                chk("qi_idle", qi, 0);
            end
            if (!in_pre) chk("mb_hold", mb, (have_op && cyc < op_e) ? mb_prev : mb_cur);
        end
    end

    task automatic tick(input bit st, input bit rst, input bit use_ops,
                        input logic [W-1:0] fa, input logic [W-1:0] fb, input logic [W-1:0] fm,
                        input bit use_seq, input logic [W-1:0] fseq);
        step_t e;
        rst_n = !rst;
        start = st;
        a_in  = use_ops ? fa : W'($urandom);
        b_in  = use_ops ? fb : W'($urandom);
        m_in  = use_ops ? fm : (W'($urandom) | W'(1));
        if (have_op && cyc >= op_e + W && cyc < op_e + 2 * W) s0 = op_s0[cyc - op_e - W];
        else s0 = 1'($urandom);
        if (st && !rst && !(have_op && cyc <= op_e + 2 * W)) begin
            have_op = 1'b1;
            op_e    = cyc + 1;
            op_s0   = use_seq ? fseq : W'($urandom);
            mb_prev = mb_cur;
            mb_cur  = {1'b0, m_in} + {1'b0, b_in};
            for (int i = 0; i < W; i++) begin
                e.ai = a_in[i];
                e.qi = op_s0[i] ^ (a_in[i] & b_in[0]);
                e.mb = mb_cur;
                step_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            have_op = 1'b0;
            mb_cur  = '0;
            mb_prev = '0;
            step_q.delete();
        end
    endtask

    task automatic go(input bit st, input bit rst);
        tick(st, rst, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) go(1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        go(1'b0, 1'b1);
        idle(4);

        tick(1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'hB5, 1'b1, 8'h39);
        idle(2 * W + 2);

        tick(1'b1, 1'b0, 1'b1, 8'h81, 8'hFF, 8'hFF, 1'b1, 8'h01);
        idle(2 * W + 2);

        // start held high: back-to-back operations with random operands every cycle
        repeat (4 * (2 * W + 2)) go(1'b1, 1'b0);
        idle(2 * W + 3);

        // Reset during relative cycle 12 of a run
        go(1'b1, 1'b0);
        idle(11);
        go(1'b0, 1'b1);
        idle(3);

        tick(1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'hB5, 1'b1, 8'h39);
        idle(2 * W + 3);

        repeat (400) go($urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0);
        idle(2 * W + 3);

        chk("step_q_empty", step_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/montgomery_select_sequencer.md
# montgomery_select_sequencer

Control-side driver for the bit-serial Montgomery multiplier's processing-element array. On `start` it latches operands A, B and modulus M and precomputes M+B with a serial adder. It then runs WIDTH iterations, each presenting the select pair (a_i, q_i) that picks 0, B, M or M+B in every processing element. It also supplies the held M+B operand and brackets the operation with busy/done.

## Interface
- `WIDTH`, default 8: operand width in bits, ≥ 2; M must be odd.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  synchronous, active-low reset.
- `start`  input  1  begin operation; sampled only in IDLE.
- `a_in`  input  WIDTH  multiplier operand A, latched on accepted start.
- `b_in`  input  WIDTH  multiplicand B, latched on accepted start.
- `m_in`  input  WIDTH  modulus M (odd), latched on accepted start.
- `s0`  input  1  LSB of the datapath's registered running sum S for the current iteration.
- `step_en`  output  1  high for each of the WIDTH iteration cycles; the datapath updates S on these cycles.
- `ai`  output  1  current A bit, LSB first; 0 when `step_en`=0.
- `qi`  output  1  quotient bit = `s0` ^ (a_i & B[0]); 0 when `step_en`=0.
- `mb`  output  WIDTH+1  M+B; valid from the first RUN cycle until the next accepted start.
- `busy`  output  1  high in any state other than IDLE.
- `done`  output  1  one-cycle pulse after the last iteration.

## Operation
- States: IDLE, PRECOMP, RUN, DONE.
- IDLE:
  - `start`=1 at the edge latches `a_in`/`b_in`/`m_in`, clears `mb`, carry and the counter, and moves to PRECOMP.
  - `start`=0 stays in IDLE.
- PRECOMP, WIDTH cycles:
  - Cycle k adds M[k]+B[k]+carry and writes the sum bit into `mb[k]`, registering the new carry.
  - On the edge ending cycle WIDTH-1, the final carry goes into `mb[WIDTH]`; the state moves to RUN and the counter clears.
- RUN, WIDTH cycles:
  - `step_en`=1, `ai`=A_reg[0], `qi`=`s0` ^ (A_reg[0] & B_reg[0]), combinational from the registered `s0`.
  - Each edge shifts A_reg right by one with zero fill and increments the counter.
  - After the WIDTH-th cycle the state moves to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` while `busy`=1 is ignored; no queuing.
- Counter width: $clog2(WIDTH+1).
- `mb` always has WIDTH+1 bits, so there is no overflow loss.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State goes to IDLE.
  - `step_en`, `ai`, `qi`, `busy`, `done` = 0.
  - `mb`, A_reg, B_reg, M_reg, carry and counter = 0.
- Reset mid-operation aborts immediately; no `done` is issued.
- Latency, with `start` sampled at edge 0:
  - PRECOMP occupies cycles 1..WIDTH.
  - RUN occupies cycles WIDTH+1..2·WIDTH.
  - `done` is high in cycle 2·WIDTH+1.
  - `busy` is high in cycles 1..2·WIDTH+1.
- The earliest next `start` is accepted at the edge ending the DONE cycle+1, i.e. the first IDLE cycle.
- `qi` carries no register stage. The datapath must present `s0` from its own register so the loop s0→qi→mux→S closes within one cycle.

## Structure
- Package `montgomery_pkg` holds:
  - the `state_t` enum (IDLE, PRECOMP, RUN, DONE);
  - a width helper function for the counter;
  - it is shared with the datapath and processing elements.
- Sub-module `serial_adder_bit`: a one-bit full adder with a registered carry, synchronous clear and an enable. It is instantiated once for the M+B precompute.
- Everything else (FSM, counter, shift register) lives in the top module.

## Test plan
- WIDTH=8, M=0xB5, B=0x3C, A=0xA5, `start` at edge 0 → `busy` rises in cycle 1; `mb`=0x0F1 from cycle 9; `step_en` high in cycles 9..16; `done` only in cycle 17.
- Same run: `ai` sequence over cycles 9..16 = 1,0,1,0,0,1,0,1. With `s0` driven 1,0,0,1,1,1,0,0 and B[0]=0, `qi` = `s0` exactly.
- M=0xFF, B=0xFF → `mb`=0x1FE (carry into bit 8). B[0]=1, A[0]=1, `s0`=1 → `qi`=0 in the first RUN cycle.
- `start` held high continuously → operations back-to-back with exactly one IDLE cycle between `done` and the next `busy` rise. Operand changes during busy have no effect.
- `rst_n`=0 in cycle 12 of a run → the next cycle shows IDLE, `busy`=0, `mb`=0, `step_en`=0, with no `done` pulse. A fresh start then completes normally with correct results.
- `step_en`=0 (IDLE/PRECOMP/DONE) with arbitrary `s0` toggling → `ai`=`qi`=0 throughout.
